// File: rtl/writeback_stage_pkg.sv
// Shared CPU definitions for the write-back stage: result-source and load-type
// encodings, datapath widths and the MEM/WB pipeline register layout.
package cpu_pkg;

  localparam int DATA_W = 32;
  localparam int REG_W  = 5;

  typedef enum logic [1:0] {
    WB_ALU  = 2'd0,
    WB_MEM  = 2'd1,
    WB_LINK = 2'd2,
    WB_RSVD = 2'd3
  } wb_sel_e;

  typedef enum logic [2:0] {
    LD_W  = 3'd0,
    LD_B  = 3'd1,
    LD_BU = 3'd2,
    LD_H  = 3'd3,
    LD_HU = 3'd4
  } load_type_e;

  typedef struct packed {
    logic              valid;
    logic              reg_write;
    wb_sel_e           mem_to_reg;
    logic [REG_W-1:0]  write_register;
    logic [DATA_W-1:0] alu_out;
    logic [DATA_W-1:0] mem_data;
    logic [DATA_W-1:0] pc_plus4;
    logic [2:0]        load_type;
  } memwb_t;

endpackage

// File: rtl/writeback_stage_if.sv
// MEM-stage inputs and register-file write port of the write-back stage.
interface writeback_stage_if;
  import cpu_pkg::*;

  logic              in_valid;
  logic              in_RegWrite;
  logic [1:0]        in_MemToReg;
  logic [REG_W-1:0]  in_Write_register;
  logic [DATA_W-1:0] in_ALU_out;
  logic [DATA_W-1:0] in_Mem_data;
  logic [DATA_W-1:0] in_PC_plus4;
  logic [2:0]        in_LoadType;

  logic              RegWrite;
  logic [REG_W-1:0]  Write_register;
  logic [DATA_W-1:0] Write_data;
  logic              Misaligned;
  logic [DATA_W-1:0] Retire_count;

  modport master (
    output in_valid, in_RegWrite, in_MemToReg, in_Write_register,
           in_ALU_out, in_Mem_data, in_PC_plus4, in_LoadType,
    input  RegWrite, Write_register, Write_data, Misaligned, Retire_count
  );

  modport slave (
    input  in_valid, in_RegWrite, in_MemToReg, in_Write_register,
           in_ALU_out, in_Mem_data, in_PC_plus4, in_LoadType,
    output RegWrite, Write_register, Write_data, Misaligned, Retire_count
  );

endinterface

// File: rtl/writeback_stage_load_extract.sv
// Little-endian load data extraction with sign/zero extension and an
// alignment check; misaligned accesses return the aligned-down data.
module load_extract
  import cpu_pkg::*;
(
  input  logic [DATA_W-1:0] raw,
  input  logic [1:0]        off,
  input  logic [2:0]        load_type,
  output logic [DATA_W-1:0] data,
  output logic              misaligned
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = raw[8*off +: 8];
    half_sel = off[1] ? raw[31:16] : raw[15:0];
  end

  always_comb begin
    data       = raw;
    misaligned = 1'b0;
    case (load_type)
      LD_B:  data = {{24{byte_sel[7]}}, byte_sel};
      LD_BU: data = {24'd0, byte_sel};
      LD_H: begin
        data       = {{16{half_sel[15]}}, half_sel};
        misaligned = off[0];
      end
      LD_HU: begin
        data       = {16'd0, half_sel};
        misaligned = off[0];
      end
      default: begin
        data       = raw;
        misaligned = (off != 2'd0);
      end
    endcase
  end

endmodule

// File: rtl/writeback_stage.sv
// MEM/WB pipeline register and write-back datapath: result select, register
// file write gating, misaligned-load flag and retired-instruction counter.
module writeback_stage
  import cpu_pkg::*;
#(
  parameter int                DATA_W        = 32,
  parameter logic [DATA_W-1:0] RESET_PC_LINK = '0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               stall,
  input  logic               flush,
  writeback_stage_if.slave   bus
);

  memwb_t            r;
  logic [DATA_W-1:0] count;
  logic [DATA_W-1:0] load_data;
  logic              load_misaligned;
  logic              misaligned;
  logic [DATA_W-1:0] result;

  // Flush only has to kill the instruction; the other fields may hold stale data.
  always_ff @(posedge clk) begin
    if (reset) begin
      r          <= '0;
      r.pc_plus4 <= RESET_PC_LINK;
      count      <= '0;
    end else begin
      if (bus.in_valid && !stall) begin
        count <= count + 1'b1;
      end
      if (flush) begin
        r.valid     <= 1'b0;
        r.reg_write <= 1'b0;
      end else if (!stall) begin
        r.valid          <= bus.in_valid;
        r.reg_write      <= bus.in_RegWrite;
        r.mem_to_reg     <= wb_sel_e'(bus.in_MemToReg);
        r.write_register <= bus.in_Write_register;
        r.alu_out        <= bus.in_ALU_out;
        r.mem_data       <= bus.in_Mem_data;
        r.pc_plus4       <= bus.in_PC_plus4;
        r.load_type      <= bus.in_LoadType;
      end
    end
  end

  load_extract u_load_extract (
    .raw        (r.mem_data),
    .off        (r.alu_out[1:0]),
    .load_type  (r.load_type),
    .data       (load_data),
    .misaligned (load_misaligned)
  );

  always_comb begin
    case (r.mem_to_reg)
      WB_MEM:  result = load_data;
      WB_LINK: result = r.pc_plus4 + 32'd4;
      default: result = r.alu_out;
    endcase
  end

  assign misaligned = r.valid && (r.mem_to_reg == WB_MEM) && load_misaligned;

  // r0 is hardwired, so writes to it are dropped here rather than in the regfile.
  assign bus.RegWrite       = r.valid && r.reg_write &&
                              (r.write_register != '0) && !misaligned;
  assign bus.Write_register = r.write_register;
  assign bus.Write_data     = result;
  assign bus.Misaligned     = misaligned;
  assign bus.Retire_count   = count;

endmodule

// File: tb/tb_writeback_stage.sv
// Scoreboard testbench for writeback_stage: directed test-plan cases followed
// by randomized traffic checked against a behavioural model.
module tb_writeback_stage;

  logic clk;
  logic reset;
  logic stall;
  logic flush;

  writeback_stage_if bus ();

  writeback_stage #(.DATA_W(32), .RESET_PC_LINK(32'h0)) dut (
    .clk   (clk),
    .reset (reset),
    .stall (stall),
    .flush (flush),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    bit          rst, stl, fl, v, rw;
    logic [1:0]  sel;
    logic [4:0]  rd;
    logic [31:0] alu, mem, pc;
    logic [2:0]  lt;
  } stim_t;

  typedef struct {
    int          cyc;
    bit          known;
    logic        rw;
    logic [4:0]  rd;
    logic [31:0] data;
    logic        mis;
    logic [31:0] cnt;
  } exp_t;

  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  exp_t sb_q[$];

  // Behavioural model: the instruction sitting in WB plus the retire count.
  stim_t       m;
  bit          m_known;
  logic [31:0] m_cnt;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic exp_t predict();
    exp_t        e;
    logic [1:0]  off;
    logic [7:0]  b;
    logic [15:0] h;
    bit          is_half, is_byte;
    off     = m.alu[1:0];
    b       = 8'((m.mem >> (8 * off)) & 32'hFF);
    h       = 16'((m.mem >> (16 * off[1])) & 32'hFFFF);
    is_half = (m.lt == 3'd3) || (m.lt == 3'd4);
    is_byte = (m.lt == 3'd1) || (m.lt == 3'd2);
    e.known = m_known;
    e.cnt   = m_cnt;
    e.rd    = m.rd;
    e.mis   = m.v && (m.sel == 2'd1) &&
              ((is_half && off[0]) || (!is_half && !is_byte && off != 2'd0));
    if (m.sel == 2'd1) begin
      case (m.lt)
        3'd1:    e.data = {{24{b[7]}}, b};
        3'd2:    e.data = {24'd0, b};
        3'd3:    e.data = {{16{h[15]}}, h};
        3'd4:    e.data = {16'd0, h};
        default: e.data = m.mem;
      endcase
    end else if (m.sel == 2'd2) begin
      e.data = m.pc + 32'd4;
    end else begin
      e.data = m.alu;
    end
    e.rw  = m.v && m.rw && (m.rd != 5'd0) && !e.mis;
    e.cyc = 0;
    return e;
  endfunction

  // Drive one cycle of inputs, advance the model, queue the expected result.
  task automatic applyStimulus(input stim_t s);
    exp_t e;
    reset                 = s.rst;
    stall                 = s.stl;
    flush                 = s.fl;
    bus.in_valid          = s.v;
    bus.in_RegWrite       = s.rw;
    bus.in_MemToReg       = s.sel;
    bus.in_Write_register = s.rd;
    bus.in_ALU_out        = s.alu;
    bus.in_Mem_data       = s.mem;
    bus.in_PC_plus4       = s.pc;
    bus.in_LoadType       = s.lt;
    if (s.rst) begin
      m       = '{default: '0};
      m_known = 1'b1;
      m_cnt   = 32'd0;
    end else begin
      if (s.v && !s.stl) m_cnt = m_cnt + 32'd1;
      if (s.fl) begin
        m.v     = 1'b0;
        m.rw    = 1'b0;
        m_known = 1'b0;
      end else if (!s.stl) begin
        m       = s;
        m_known = 1'b1;
      end
    end
    e     = predict();
    e.cyc = cyc + 1;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic step(input bit rst, stl, fl, v, rw, input logic [1:0] sel,
                      input logic [4:0] rd, input logic [31:0] alu, mem, pc,
                      input logic [2:0] lt);
    stim_t s;
    s = '{rst: rst, stl: stl, fl: fl, v: v, rw: rw, sel: sel, rd: rd,
          alu: alu, mem: mem, pc: pc, lt: lt};
    applyStimulus(s);
  endtask

  task automatic checkOutput(input string name, input bit chk_data,
                             input logic rw, input logic [4:0] rd,
                             input logic [31:0] data, input logic mis,
                             input logic [31:0] cnt);
    bit bad;
    checks++;
    bad = (bus.RegWrite !== rw) || (bus.Misaligned !== mis) ||
          (bus.Retire_count !== cnt);
    if (chk_data) bad = bad || (bus.Write_register !== rd) || (bus.Write_data !== data);
    if (bad) begin
      failures++;
      $display("[TB] FAIL %s: got rw=%b rd=%0d data=%h mis=%b cnt=%0d, want rw=%b rd=%0d data=%h mis=%b cnt=%0d",
               name, bus.RegWrite, bus.Write_register, bus.Write_data, bus.Misaligned,
               bus.Retire_count, rw, rd, data, mis, cnt);
    end
  endtask

  // Monitor: compare every cycle the queued prediction for that cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb_q.size() > 0 && sb_q[0].cyc == cyc) begin
        e = sb_q.pop_front();
        checkOutput($sformatf("scoreboard cycle %0d", e.cyc), e.known,
                    e.rw, e.rd, e.data, e.mis, e.cnt);
      end
    end
  end

  initial begin
    stim_t s;
    step(1, 0, 0, 0, 0, 2'd0, 5'd0, 32'h0, 32'h0, 32'h0, 3'd0);
    checkOutput("reset", 1, 0, 5'd0, 32'h0, 0, 32'd0);
    step(0, 0, 0, 1, 1, 2'd0, 5'd5, 32'h12345678, 32'h0, 32'h0, 3'd0);
    checkOutput("alu op", 1, 1, 5'd5, 32'h12345678, 0, 32'd1);

    for (int i = 0; i < 4; i++) begin
      logic [31:0] want [4] = '{32'h00000001, 32'h0000007F, 32'hFFFFFFFF, 32'hFFFFFF80};
      step(0, 0, 0, 1, 1, 2'd1, 5'd1, 32'h100 + 32'(i), 32'h80FF7F01, 32'h0, 3'd1);
      checkOutput($sformatf("lb off%0d", i), 1, 1, 5'd1, want[i], 0, 32'(2 + i));
    end
    step(0, 0, 0, 1, 1, 2'd1, 5'd1, 32'h103, 32'h80FF7F01, 32'h0, 3'd2);
    checkOutput("lbu off3", 1, 1, 5'd1, 32'h00000080, 0, 32'd6);
    step(0, 0, 0, 1, 1, 2'd1, 5'd2, 32'h202, 32'h80011234, 32'h0, 3'd3);
    checkOutput("lh off2", 1, 1, 5'd2, 32'hFFFF8001, 0, 32'd7);
    step(0, 0, 0, 1, 1, 2'd1, 5'd2, 32'h202, 32'h80011234, 32'h0, 3'd4);
    checkOutput("lhu off2", 1, 1, 5'd2, 32'h00008001, 0, 32'd8);
    step(0, 0, 0, 1, 1, 2'd1, 5'd2, 32'h201, 32'h80011234, 32'h0, 3'd3);
    checkOutput("lh off1 misaligned", 1, 0, 5'd2, 32'h00001234, 1, 32'd9);
    step(0, 0, 0, 1, 1, 2'd1, 5'd3, 32'h202, 32'h80011234, 32'h0, 3'd0);
    checkOutput("lw off2 misaligned", 1, 0, 5'd3, 32'h80011234, 1, 32'd10);
    step(0, 0, 0, 1, 1, 2'd2, 5'd31, 32'h0, 32'h0, 32'h00400010, 3'd0);
    checkOutput("link", 1, 1, 5'd31, 32'h00400014, 0, 32'd11);
    step(0, 0, 0, 1, 1, 2'd0, 5'd0, 32'h0000DEAD, 32'h0, 32'h0, 3'd0);
    checkOutput("write r0", 1, 0, 5'd0, 32'h0000DEAD, 0, 32'd12);

    step(0, 0, 0, 1, 1, 2'd0, 5'd7, 32'h77, 32'h0, 32'h0, 3'd0);
    checkOutput("pre-stall", 1, 1, 5'd7, 32'h77, 0, 32'd13);
    for (int i = 0; i < 3; i++) begin
      step(0, 1, 0, 1, 1, 2'd0, 5'd8, 32'h88, 32'h0, 32'h0, 3'd0);
      checkOutput($sformatf("stall hold %0d", i), 1, 1, 5'd7, 32'h77, 0, 32'd13);
    end
    step(0, 0, 0, 1, 1, 2'd0, 5'd8, 32'h88, 32'h0, 32'h0, 3'd0);
    checkOutput("stall release", 1, 1, 5'd8, 32'h88, 0, 32'd14);
    step(0, 1, 1, 1, 1, 2'd0, 5'd9, 32'h99, 32'h0, 32'h0, 3'd0);
    checkOutput("flush over stall", 0, 0, 5'd0, 32'h0, 0, 32'd14);
    step(0, 0, 0, 1, 1, 2'd0, 5'd9, 32'h99, 32'h0, 32'h0, 3'd0);
    checkOutput("post flush", 1, 1, 5'd9, 32'h99, 0, 32'd15);
    step(1, 1, 0, 1, 1, 2'd0, 5'd10, 32'hAA, 32'h0, 32'h0, 3'd0);
    checkOutput("reset during stall", 1, 0, 5'd0, 32'h0, 0, 32'd0);

    for (int i = 0; i < 1500; i++) begin
      s.rst = ($urandom_range(0, 99) == 0);
      s.stl = ($urandom_range(0, 4) == 0);
      s.fl  = ($urandom_range(0, 9) == 0);
      s.v   = s.fl ? 1'b0 : ($urandom_range(0, 3) != 0);
      s.rw  = ($urandom_range(0, 7) != 0);
      s.sel = 2'($urandom_range(0, 3));
      s.rd  = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
      s.alu = $urandom;
      s.mem = $urandom;
      s.pc  = ($urandom_range(0, 7) == 0) ? 32'hFFFFFFFC : $urandom;
      s.lt  = 3'($urandom_range(0, 7));
      applyStimulus(s);
    end

    step(0, 0, 0, 0, 0, 2'd0, 5'd0, 32'h0, 32'h0, 32'h0, 3'd0);
    repeat (4) @(negedge clk);
    checks++;
    if (sb_q.size() != 0) begin
      failures++;
      $display("[TB] FAIL scoreboard drain: got %0d pending, want 0", sb_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
